// File: rtl/row_accum_pkg.sv
// Shared types and constants for the row accumulator.
package row_accum_pkg;

    // Fill side state: FILL accepts pixels, HOLD parks a finished row
    // while the output register is still occupied.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_t;

    // RGB444 field positions inside a default 12-bit pixel.
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // Width of a packed row word (ROW_W = PIX_W * ROW_PIX).
    function automatic int row_width(input int pix_w, input int row_pix);
        return pix_w * row_pix;
    endfunction

endpackage

// File: rtl/row_accum.sv
// Row accumulator: packs PIX_W-bit pixels into ROW_PIX-pixel row words.
// A fill register collects the current row while an output register
// presents the previous one, so intake continues while a row waits.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. Valid, once raised, is held with its data stable until
// that edge; ready may change freely and never depends on valid.
module row_accum
    import row_accum_pkg::*;
#(
    parameter int PIX_W   = 12,
    parameter int ROW_PIX = 256,
    parameter int ROWS    = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               msb_first,
    input  logic                               pix_valid,
    output logic                               pix_ready,
    input  logic [PIX_W-1:0]                   pix_data,
    output logic                               row_valid,
    input  logic                               row_ready,
    output logic [PIX_W*ROW_PIX-1:0]           row_data,
    output logic [$clog2(ROWS)-1:0]            row_idx,
    output logic [$clog2(ROW_PIX)-1:0]         pix_cnt,
    output logic                               frame_done
);

    localparam int ROW_W = row_width(PIX_W, ROW_PIX);
    localparam int CNT_W = $clog2(ROW_PIX);
    localparam int IDX_W = $clog2(ROWS);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(ROW_PIX - 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    fill_state_t      state_q;
    logic [ROW_W-1:0] fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] wr_q;
    logic             msb_q;
    logic             row_valid_q;
    logic [ROW_W-1:0] row_data_q;
    logic [IDX_W-1:0] row_idx_q;
    logic             frame_done_q;

    logic             accept;
    logic             row_last;
    logic             out_hs;
    logic             out_free;
    logic             order_d;
    logic [ROW_W-1:0] fill_d;
    logic             load_direct;
    logic             load_hold;
    logic [IDX_W-1:0] wr_d;

    assign pix_ready  = (state_q == FILL);
    assign row_valid  = row_valid_q;
    assign row_data   = row_data_q;
    assign row_idx    = row_idx_q;
    assign pix_cnt    = cnt_q;
    assign frame_done = frame_done_q;

    // clr outranks a pixel offered in the same cycle.
    assign accept   = pix_valid && pix_ready && !clr;
    assign row_last = accept && (cnt_q == LAST_PIX);
    assign out_hs   = row_valid_q && row_ready;
    assign out_free = !row_valid_q || row_ready;

    // Packing order is taken live on a row's first pixel, latched after.
    assign order_d = (cnt_q == '0) ? msb_first : msb_q;
    assign fill_d  = order_d ? {fill_q[ROW_W-PIX_W-1:0], pix_data}
                             : {pix_data, fill_q[ROW_W-1:PIX_W]};

    // A completed row goes straight out when the output register frees up
    // this cycle; a parked row goes out when the presented one is taken.
    assign load_direct = row_last && out_free;
    assign load_hold   = (state_q == HOLD) && out_hs && !clr;
    assign wr_d        = (wr_q == LAST_ROW) ? '0 : wr_q + 1'b1;

    // Fill FSM, fill datapath, output register and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            fill_q       <= '0;
            cnt_q        <= '0;
            wr_q         <= '0;
            msb_q        <= 1'b0;
            row_valid_q  <= 1'b0;
            row_data_q   <= '0;
            row_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (clr) begin
                state_q <= FILL;
                fill_q  <= '0;
                cnt_q   <= '0;
                wr_q    <= '0;
                msb_q   <= 1'b0;
            end else begin
                case (state_q)
                    FILL: begin
                        if (accept) begin
                            if (cnt_q == '0) begin
                                msb_q <= msb_first;
                            end
                            if (row_last) begin
                                cnt_q <= '0;
                                if (out_free) begin
                                    fill_q <= '0;
                                    wr_q   <= wr_d;
                                end else begin
                                    fill_q  <= fill_d;
                                    state_q <= HOLD;
                                end
                            end else begin
                                cnt_q  <= cnt_q + 1'b1;
                                fill_q <= fill_d;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_hs) begin
                            fill_q  <= '0;
                            wr_q    <= wr_d;
                            state_q <= FILL;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end

            // Output register drains normally regardless of clr.
            if (load_direct || load_hold) begin
                row_data_q  <= load_hold ? fill_q : fill_d;
                row_idx_q   <= wr_q;
                row_valid_q <= 1'b1;
            end else if (out_hs) begin
                row_valid_q <= 1'b0;
            end

            frame_done_q <= out_hs && (row_idx_q == LAST_ROW);
        end
    end

endmodule

// File: tb/tb_row_accum.sv
// Bench for row_accum: small configuration (4 pixels x 3 rows) driven from a
// vector table and directed sequences, default configuration driven with
// random pixels against a row-building reference model.
module tb_row_accum;

    localparam int PW     = 12;
    localparam int S_PIX  = 4;
    localparam int S_ROWS = 3;
    localparam int L_PIX  = 256;
    localparam int L_ROWS = 256;
    localparam int S_W    = PW * S_PIX;
    localparam int L_W    = PW * L_PIX;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic l_rst_n;
    always #5 clk = ~clk;

    // small instance
    logic           s_clr, s_msb, s_pv, s_rr;
    logic [PW-1:0]  s_pd;
    logic           s_pr, s_rv, s_fd;
    logic [S_W-1:0] s_rd;
    logic [1:0]     s_ri;
    logic [1:0]     s_pc;

    // default-size instance
    logic           l_clr, l_msb, l_pv, l_rr;
    logic [PW-1:0]  l_pd;
    logic           l_pr, l_rv, l_fd;
    logic [L_W-1:0] l_rd;
    logic [7:0]     l_ri;
    logic [7:0]     l_pc;

    row_accum #(.PIX_W(PW), .ROW_PIX(S_PIX), .ROWS(S_ROWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .msb_first(s_msb),
        .pix_valid(s_pv), .pix_ready(s_pr), .pix_data(s_pd),
        .row_valid(s_rv), .row_ready(s_rr), .row_data(s_rd),
        .row_idx(s_ri), .pix_cnt(s_pc), .frame_done(s_fd)
    );

    row_accum #(.PIX_W(PW), .ROW_PIX(L_PIX), .ROWS(L_ROWS)) dut_l (
        .clk(clk), .rst_n(l_rst_n), .clr(l_clr), .msb_first(l_msb),
        .pix_valid(l_pv), .pix_ready(l_pr), .pix_data(l_pd),
        .row_valid(l_rv), .row_ready(l_rr), .row_data(l_rd),
        .row_idx(l_ri), .pix_cnt(l_pc), .frame_done(l_fd)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;

    logic [PW-1:0]  cur_q[$];
    bit             cur_msb;
    int             row_ctr;
    logic [L_W-1:0] exp_q[$];
    int             exp_idx_q[$];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [L_W-1:0] act, input logic [L_W-1:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = 0;
            for (int i = 0; i < L_PIX; i++) begin
                if (act[i*PW +: PW] !== exp[i*PW +: PW]) begin
                    first = i;
                    break;
                end
            end
            $display("FAIL %s: pixel slot %0d got %03h expected %03h", name, first,
                     act[first*PW +: PW], exp[first*PW +: PW]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_clear();
        s_pv  = 1'b0;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
    endtask

    task automatic s_push(input logic [PW-1:0] d);
        s_pv = 1'b1;
        s_pd = d;
        tick();
    endtask

    // Expected row from the pixels in arrival order: pixel i goes to slot i
    // (LSB first) or to slot ROW_PIX-1-i (MSB first).
    function automatic logic [L_W-1:0] model_row();
        logic [L_W-1:0] r;
        r = '0;
        for (int i = 0; i < L_PIX; i++) begin
            if (cur_msb) r[(L_PIX-1-i)*PW +: PW] = cur_q[i];
            else         r[i*PW +: PW]           = cur_q[i];
        end
        return r;
    endfunction

    // Drive npix pixels into the large instance, scoring every row handshake.
    task automatic run_large(input int npix, input bit full_rate, input bit hold_rr0,
                             input int budget, output int cycles);
        int  sent;
        bit  acc, hs;
        sent   = 0;
        cycles = 0;
        while ((sent < npix || (exp_q.size() > 0 && !hold_rr0)) && cycles < budget) begin
            if (sent < npix) begin
                l_pv  = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
                l_pd  = PW'($urandom_range(0, 4095));
                l_msb = 1'($urandom_range(0, 1));
            end else begin
                l_pv = 1'b0;
            end
            l_rr = hold_rr0 ? 1'b0 : (full_rate ? 1'b1 : ($urandom_range(0, 3) != 0));
            acc  = l_pv && l_pr;
            hs   = l_rv && l_rr;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got idx %0d expected no row", l_ri);
                end else begin
                    chk_row("rand_row_data", l_rd, exp_q.pop_front());
                    chk("rand_row_idx", l_ri, exp_idx_q.pop_front());
                end
            end
            if (acc) begin
                if (cur_q.size() == 0) cur_msb = l_msb;
                cur_q.push_back(l_pd);
                sent++;
                if (cur_q.size() == L_PIX) begin
                    exp_q.push_back(model_row());
                    exp_idx_q.push_back(row_ctr);
                    row_ctr = (row_ctr + 1) % L_ROWS;
                    cur_q.delete();
                end
            end
            tick();
            cycles++;
        end
        l_pv = 1'b0;
        if (cycles >= budget) begin
            checks++;
            errors++;
            $display("FAIL run_budget: got %0d cycles expected under %0d", cycles, budget);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic                msb;
        logic                tog;
        logic [3:0][PW-1:0]  px;
        logic [S_W-1:0]      exp;
    } vec_t;

    vec_t vt[6];

    task automatic set_vec(input int i, input logic msb, input logic tog,
                           input logic [3:0][PW-1:0] px, input logic [S_W-1:0] exp);
        vt[i].msb = msb;
        vt[i].tog = tog;
        vt[i].px  = px;
        vt[i].exp = exp;
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        int fd_cnt, fd_at, cyc;
        logic [S_W-1:0] held;

        rst_n = 1'b0; l_rst_n = 1'b0;
        s_clr = 0; s_msb = 0; s_pv = 0; s_rr = 0; s_pd = '0;
        l_clr = 0; l_msb = 0; l_pv = 0; l_rr = 0; l_pd = '0;
        cur_msb = 0; row_ctr = 0;

        // px packed as {p3,p2,p1,p0}
        set_vec(0, 1'b0, 1'b0, {12'h004, 12'h003, 12'h002, 12'h001}, 48'h004003002001);
        set_vec(1, 1'b1, 1'b0, {12'h004, 12'h003, 12'h002, 12'h001}, 48'h001002003004);
        set_vec(2, 1'b1, 1'b1, {12'h004, 12'h003, 12'h002, 12'h001}, 48'h001002003004);
        set_vec(3, 1'b0, 1'b1, {12'h004, 12'h003, 12'h002, 12'h001}, 48'h004003002001);
        set_vec(4, 1'b0, 1'b0, {12'h456, 12'h123, 12'hDEF, 12'hABC}, 48'h456123DEFABC);
        set_vec(5, 1'b1, 1'b0, {12'h456, 12'h123, 12'hDEF, 12'hABC}, 48'hABCDEF123456);

        repeat (3) tick();
        rst_n = 1'b1; l_rst_n = 1'b1;

        // Reset state
        chk("rst_row_valid", s_rv, 0);
        chk("rst_pix_ready", s_pr, 1);
        chk("rst_pix_cnt", s_pc, 0);
        chk("rst_row_idx", s_ri, 0);
        chk("rst_row_data", s_rd, 0);
        chk("rst_frame_done", s_fd, 0);
        chk("rst_l_row_valid", l_rv, 0);
        chk_row("rst_l_row_data", l_rd, '0);

        // Table: one row each, row_ready high
        s_rr = 1'b1;
        for (int v = 0; v < 6; v++) begin
            s_clear();
            s_msb = vt[v].msb;
            for (int k = 0; k < 4; k++) begin
                chk("tbl_pix_ready", s_pr, 1);
                s_push(vt[v].px[k]);
                if (vt[v].tog && k == 1) s_msb = ~vt[v].msb;
                if (k < 3) chk("tbl_early_valid", s_rv, 0);
            end
            s_pv = 1'b0;
            chk("tbl_row_valid", s_rv, 1);
            chk("tbl_row_data", s_rd, vt[v].exp);
            chk("tbl_row_idx", s_ri, 0);
            chk("tbl_pix_cnt", s_pc, 0);
            tick();
            chk("tbl_drain", s_rv, 0);
        end

        // Four rows back to back: idx 0,1,2,0 and one frame_done pulse
        s_clear();
        s_rr = 1'b1; s_msb = 1'b0;
        fd_cnt = 0; fd_at = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 16) begin
                s_pv = 1'b1;
                s_pd = PW'(c);
            end else begin
                s_pv = 1'b0;
            end
            tick();
            if (s_fd) begin
                fd_cnt++;
                fd_at = c;
            end
            if (c % 4 == 0 && c <= 16) begin
                chk("fd_row_valid", s_rv, 1);
                chk("fd_row_idx", s_ri, (c / 4 - 1) % S_ROWS);
            end
            if (c == 12) chk("fd_row2_data", s_rd, 48'h00C00B00A009);
            if (c == 16) chk("fd_row3_data", s_rd, 48'h01000F00E00D);
        end
        chk("fd_pulse_count", fd_cnt, 1);
        chk("fd_pulse_cycle", fd_at, 13);

        // Backpressure across two rows
        s_clear();
        s_rr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            s_push((c <= 4) ? 12'h111 : 12'h222);
            if (c == 7) chk("bp_ready_before_hold", s_pr, 1);
        end
        chk("bp_ready_low", s_pr, 0);
        chk("bp_row_valid", s_rv, 1);
        chk("bp_row_data", s_rd, 48'h111111111111);
        chk("bp_row_idx", s_ri, 0);
        s_pv = 1'b1; s_pd = 12'h333;
        repeat (3) tick();
        chk("bp_data_stable", s_rd, 48'h111111111111);
        chk("bp_ready_still_low", s_pr, 0);
        s_rr = 1'b1;
        tick();
        s_pv = 1'b0;
        chk("bp_release_data", s_rd, 48'h222222222222);
        chk("bp_release_idx", s_ri, 1);
        chk("bp_release_valid", s_rv, 1);
        chk("bp_release_ready", s_pr, 1);
        tick();
        chk("bp_drain", s_rv, 0);
        chk("bp_pix_cnt", s_pc, 0);

        // clr mid-row with a pending output row
        s_clear();
        s_rr = 1'b0; s_msb = 1'b0;
        repeat (4) s_push(12'hAAA);
        s_push(12'h555);
        s_push(12'h555);
        chk("clr_pre_pix_cnt", s_pc, 2);
        held = 48'hAAAAAAAAAAAA;
        s_pv = 1'b1; s_pd = 12'h777; s_clr = 1'b1;
        tick();
        s_clr = 1'b0; s_pv = 1'b0;
        chk("clr_priority_pix_cnt", s_pc, 0);
        chk("clr_keeps_valid", s_rv, 1);
        chk("clr_keeps_data", s_rd, held);
        chk("clr_keeps_idx", s_ri, 0);
        s_push(12'h00B); s_push(12'h00C); s_push(12'h00D); s_push(12'h00E);
        s_pv = 1'b0;
        chk("clr_hold_ready", s_pr, 0);
        chk("clr_pending_data", s_rd, held);
        s_rr = 1'b1;
        tick();
        chk("clr_new_row_data", s_rd, 48'h00E00D00C00B);
        chk("clr_new_row_idx", s_ri, 0);
        chk("clr_new_row_valid", s_rv, 1);
        tick();
        chk("clr_drain", s_rv, 0);

        // Default size: one row at full rate, then random rows
        run_large(L_PIX, 1'b1, 1'b0, 1000, cyc);
        chk("full_rate_cycles", cyc, L_PIX + 1);
        run_large(2 * L_PIX, 1'b0, 1'b0, 6000, cyc);

        // Pending row plus a partial row, then asynchronous reset
        run_large(L_PIX, 1'b1, 1'b1, 600, cyc);
        run_large(100, 1'b1, 1'b1, 600, cyc);
        chk("prerst_row_valid", l_rv, 1);
        chk("prerst_pix_cnt", l_pc, 100);
        #2;
        l_rst_n = 1'b0;
        #1;
        chk("arst_row_valid", l_rv, 0);
        chk("arst_pix_cnt", l_pc, 0);
        chk("arst_row_idx", l_ri, 0);
        chk("arst_pix_ready", l_pr, 1);
        chk_row("arst_row_data", l_rd, '0);
        cur_q.delete();
        exp_q.delete();
        exp_idx_q.delete();
        row_ctr = 0;
        @(negedge clk);
        l_rst_n = 1'b1;
        tick();
        run_large(L_PIX, 1'b0, 1'b0, 3000, cyc);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/row_accum.md
Name: row_accum

Overview:
- Parametrised row accumulator. Collects PIX_W-bit pixels into a ROW_PIX-pixel row word and hands complete rows to the image buffer writer.
- Next generation of the single-shift accumulator:
  - pixel counting and a row-complete indication;
  - valid/ready handshakes on both sides;
  - ping-pong buffering (fill register plus output register), so pixel intake continues while a finished row waits;
  - selectable pixel packing order;
  - row index tracking with a frame-done pulse.
- Sits between the pixel source (camera/VGA capture or coprocessor writeback) and the image buffer write port.

Parameters:
- PIX_W, 12, bits per pixel (R[11:8] G[7:4] B[3:0] for default).
- ROW_PIX, 256, pixels per row; must be >= 2.
- ROWS, 256, rows per frame; sets row_idx width and wrap point; must be >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous frame restart: discard partial/held row, zero counters.
- msb_first  in  1  packing order: 0 = pixel 0 at LSB, 1 = pixel 0 at MSB.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  accumulator can accept a pixel.
- pix_data  in  PIX_W  input pixel.
- row_valid  out  1  row_data holds a complete row.
- row_ready  in  1  downstream accepts row.
- row_data  out  PIX_W*ROW_PIX  completed row.
- row_idx  out  $clog2(ROWS)  index of row presented on row_data.
- pix_cnt  out  $clog2(ROW_PIX)  pixels currently in fill register.
- frame_done  out  1  one-cycle pulse when row ROWS-1 is accepted downstream.

Behaviour:
- Reset (rst_n low, async):
  - fill register, row_data, pix_cnt, row_idx and the internal write row counter all 0;
  - row_valid=0, frame_done=0, pix_ready=1, fill FSM in FILL.
- Pixel accept occurs when pix_valid && pix_ready.
- Packing:
  - msb_first=0: fill <= {pix_data, fill[top:PIX_W]}. After ROW_PIX accepts, pixel 0 sits at bits [PIX_W-1:0].
  - msb_first=1: fill <= {fill[top-PIX_W:0], pix_data}. Pixel 0 ends at the MSB slot.
  - msb_first is latched on the first accepted pixel of each row; changes mid-row are ignored until the next row.
- pix_cnt increments per accept. On the accept with pix_cnt==ROW_PIX-1 the row completes and pix_cnt returns to 0.
- Fill FSM has two states, FILL and HOLD.
  - FILL: pix_ready=1.
  - On row completion, if the output register is free this cycle (!row_valid || row_ready), the completed row (including the final pixel) loads into row_data. The same edge sets row_valid=1 and row_idx=write row counter. FSM stays in FILL.
  - On row completion otherwise, the FSM goes to HOLD.
  - HOLD: pix_ready=0. When row_ready is seen with row_valid=1, the fill register transfers to row_data on that edge. row_valid stays 1, the FSM returns to FILL and the fill register clears.
- Latency and throughput:
  - row_valid rises the cycle after the last pixel is accepted.
  - Sustained rate is 1 pixel/clk with no stall when row_ready=1.
- Output side:
  - row_valid falls after row_valid && row_ready unless a new row loads on the same edge.
  - row_data and row_idx are held stable while row_valid && !row_ready.
- Write row counter advances on every transfer into row_data and wraps from ROWS-1 to 0.
- frame_done=1 for exactly the cycle after a handshake with row_idx==ROWS-1.
- clr, priority over pixel accept in the same cycle:
  - clears pix_cnt, fill register, write row counter and the latched packing order;
  - forces FSM to FILL, which drops any HOLD row;
  - does not touch row_data, row_valid or row_idx; a pending output row still drains normally.
- Reset mid-row discards all state with no output.

Decomposition:
- Package row_accum_pkg:
  - ROW_W = PIX_W*ROW_PIX;
  - fill_state_t enum {FILL, HOLD};
  - RGB444 field constants (R_MSB=11 … B_LSB=0).
- Sub-module: none required; FSM, datapath and output register are written as one block.

Test Plan:
- Small config (PIX_W=12, ROW_PIX=4, ROWS=3), msb_first=0:
  - stimulus: stream 0x001, 0x002, 0x003, 0x004 with row_ready=1;
  - response: row_valid rises 1 cycle after the 4th accept, row_data=0x004003002001, row_idx=0, pix_ready stays 1.
- Same pixels, msb_first=1 -> row_data=0x001002003004; toggling msb_first after the 2nd pixel has no effect on that row.
- Backpressure:
  - stimulus: hold row_ready=0 across 2 full rows (0x111×4 then 0x222×4);
  - response: pix_ready drops after the 8th accept; row_data stays 0x111111111111 with idx 0.
  - stimulus: release row_ready;
  - response: next edge shows row_data=0x222222222222 with idx 1, pix_ready back to 1.
- 3 rows accepted back-to-back -> frame_done pulses once, after the idx 2 handshake; the 4th row carries idx 0.
- clr after 2 pixels of a row, then 4 new pixels -> row_data contains only the new 4 pixels, row_idx=0; a pending output row is unchanged and still drains.
- Default config (PIX_W=12, ROW_PIX=256, ROWS=256):
  - stimulus: 256 random pixels at 1/clk; separately, assert rst_n low mid-row;
  - response: packing matches the reference model; reset forces row_valid=0, pix_cnt=0, row_data=0 asynchronously.
